memory_port_arbiter: RTL and testbench

MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

---
 rtl/memory_port_arbiter.sv | 124 ++++++++++++
 tb/tb_memory_port_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_port_arbiter.sv
// Two-requester (inst/data) arbiter in front of one synchronous RAM port.
// Round-robin on ties, latency-1 responses with a one-entry skid buffer per requester.
module memory_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    inst_req_valid,
    output logic                    inst_req_ready,
    input  logic [DATA_WIDTH/8-1:0] inst_req_write_strobe,
    input  logic [ADDR_WIDTH-1:0]   inst_req_address,
    input  logic [DATA_WIDTH-1:0]   inst_req_write_data,
    output logic                    inst_resp_valid,
    input  logic                    inst_resp_ready,
    output logic [DATA_WIDTH-1:0]   inst_resp_data,

    input  logic                    data_req_valid,
    output logic                    data_req_ready,
    input  logic [DATA_WIDTH/8-1:0] data_req_write_strobe,
    input  logic [ADDR_WIDTH-1:0]   data_req_address,
    input  logic [DATA_WIDTH-1:0]   data_req_write_data,
    output logic                    data_resp_valid,
    input  logic                    data_resp_ready,
    output logic [DATA_WIDTH-1:0]   data_resp_data,

    output logic                    ram_enabled,
    output logic [DATA_WIDTH/8-1:0] ram_write_strobe,
    output logic [ADDR_WIDTH-1:0]   ram_address,
    output logic [DATA_WIDTH-1:0]   ram_write_data,
    input  logic [DATA_WIDTH-1:0]   ram_read_data
);

    // last_grant: 1 = data granted most recently, 0 = inst
    logic                  last_grant_q, last_grant_d;
    logic                  infl_valid_q, infl_valid_d;
    logic                  infl_data_q,  infl_data_d;
    logic                  infl_write_q, infl_write_d;
    logic                  ibuf_valid_q, ibuf_valid_d;
    logic [DATA_WIDTH-1:0] ibuf_data_q,  ibuf_data_d;
    logic                  dbuf_valid_q, dbuf_valid_d;
    logic [DATA_WIDTH-1:0] dbuf_data_q,  dbuf_data_d;

    logic                  i_infl, d_infl;
    logic                  i_elig, d_elig;
    logic                  gnt_i,  gnt_d;
    logic [DATA_WIDTH-1:0] bypass_data;

    // Response paths: buffered data has priority over the RAM bypass
    always_comb begin
        i_infl          = infl_valid_q & ~infl_data_q;
        d_infl          = infl_valid_q &  infl_data_q;
        bypass_data     = infl_write_q ? '0 : ram_read_data;
        inst_resp_valid = ~reset & (ibuf_valid_q | i_infl);
        data_resp_valid = ~reset & (dbuf_valid_q | d_infl);
        inst_resp_data  = ibuf_valid_q ? ibuf_data_q
                        : (i_infl ? bypass_data : '0);
        data_resp_data  = dbuf_valid_q ? dbuf_data_q
                        : (d_infl ? bypass_data : '0);
    end

    // Eligibility and round-robin grant; RAM port follows the winner
    always_comb begin
        i_elig = inst_req_valid & (~inst_resp_valid | inst_resp_ready);
        d_elig = data_req_valid & (~data_resp_valid | data_resp_ready);
        gnt_i  = ~reset & i_elig & (~d_elig | last_grant_q);
        gnt_d  = ~reset & d_elig & (~i_elig | ~last_grant_q);
        inst_req_ready   = gnt_i;
        data_req_ready   = gnt_d;
        ram_enabled      = gnt_i | gnt_d;
        ram_write_strobe = '0;
        ram_address      = '0;
        ram_write_data   = '0;
        if (gnt_i) begin
            ram_write_strobe = inst_req_write_strobe;
            ram_address      = inst_req_address;
            ram_write_data   = inst_req_write_data;
        end else if (gnt_d) begin
            ram_write_strobe = data_req_write_strobe;
            ram_address      = data_req_address;
            ram_write_data   = data_req_write_data;
        end
    end

    // Next state: grant history, in-flight tag, skid buffers
    always_comb begin
        last_grant_d = gnt_d ? 1'b1 : (gnt_i ? 1'b0 : last_grant_q);
        infl_valid_d = gnt_i | gnt_d;
        infl_data_d  = gnt_d;
        infl_write_d = gnt_d ? |data_req_write_strobe
                             : (gnt_i & |inst_req_write_strobe);
        ibuf_valid_d = ibuf_valid_q ? ~inst_resp_ready
                                    : (i_infl & ~inst_resp_ready);
        ibuf_data_d  = (~ibuf_valid_q & i_infl) ? bypass_data : ibuf_data_q;
        dbuf_valid_d = dbuf_valid_q ? ~data_resp_ready
                                    : (d_infl & ~data_resp_ready);
        dbuf_data_d  = (~dbuf_valid_q & d_infl) ? bypass_data : dbuf_data_q;
    end

    // State registers; reset drops any in-flight access
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b0;
            infl_valid_q <= 1'b0;
            infl_data_q  <= 1'b0;
            infl_write_q <= 1'b0;
            ibuf_valid_q <= 1'b0;
            ibuf_data_q  <= '0;
            dbuf_valid_q <= 1'b0;
            dbuf_data_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            infl_valid_q <= infl_valid_d;
            infl_data_q  <= infl_data_d;
            infl_write_q <= infl_write_d;
            ibuf_valid_q <= ibuf_valid_d;
            ibuf_data_q  <= ibuf_data_d;
            dbuf_valid_q <= dbuf_valid_d;
            dbuf_data_q  <= dbuf_data_d;
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: directed scenarios then random traffic,
// checked against a per-requester pending-response model and a RAM array.
module tb_memory_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req_valid = 0, inst_req_ready;
    logic [3:0]  inst_req_write_strobe = 0;
    logic [31:0] inst_req_address = 0, inst_req_write_data = 0;
    logic        inst_resp_valid, inst_resp_ready = 1;
    logic [31:0] inst_resp_data;
    logic        data_req_valid = 0, data_req_ready;
    logic [3:0]  data_req_write_strobe = 0;
    logic [31:0] data_req_address = 0, data_req_write_data = 0;
    logic        data_resp_valid, data_resp_ready = 1;
    logic [31:0] data_resp_data;
    logic        ram_enabled;
    logic [3:0]  ram_write_strobe;
    logic [31:0] ram_address, ram_write_data;
    logic [31:0] ram_read_data = 0;

    memory_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
        .inst_req_write_strobe(inst_req_write_strobe),
        .inst_req_address(inst_req_address),
        .inst_req_write_data(inst_req_write_data),
        .inst_resp_valid(inst_resp_valid), .inst_resp_ready(inst_resp_ready),
        .inst_resp_data(inst_resp_data),
        .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
        .data_req_write_strobe(data_req_write_strobe),
        .data_req_address(data_req_address),
        .data_req_write_data(data_req_write_data),
        .data_resp_valid(data_resp_valid), .data_resp_ready(data_resp_ready),
        .data_resp_data(data_resp_data),
        .ram_enabled(ram_enabled), .ram_write_strobe(ram_write_strobe),
        .ram_address(ram_address), .ram_write_data(ram_write_data),
        .ram_read_data(ram_read_data)
    );

    always #5 clock = ~clock;

    // Synchronous RAM: read-before-write, byte strobes
    logic [31:0] mem [256];
    always @(posedge clock) begin
        if (ram_enabled) begin
            ram_read_data <= mem[ram_address[9:2]];
            for (int b = 0; b < 4; b++)
                if (ram_write_strobe[b])
                    mem[ram_address[9:2]][8*b +: 8] <= ram_write_data[8*b +: 8];
        end
    end

    int total = 0;
    int passed = 0;

    // Reference: each requester holds at most one owed response
    bit          m_pend [2];
    logic [31:0] m_data [2];
    int          m_last;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pend[0] = 0; m_pend[1] = 0;
        m_data[0] = 0; m_data[1] = 0;
        m_last = 0;
    endtask

    // One cycle: sample at negedge, compare, advance model, return at posedge+1
    task automatic step(string tag);
        logic        v [2];
        logic        rr [2];
        logic [3:0]  s [2];
        logic [31:0] a [2];
        logic [31:0] w [2];
        bit          el [2];
        int          g;
        @(negedge clock);
        v[0] = inst_req_valid;  v[1] = data_req_valid;
        rr[0] = inst_resp_ready; rr[1] = data_resp_ready;
        s[0] = inst_req_write_strobe; s[1] = data_req_write_strobe;
        a[0] = inst_req_address; a[1] = data_req_address;
        w[0] = inst_req_write_data; w[1] = data_req_write_data;
        for (int p = 0; p < 2; p++)
            el[p] = v[p] && (!m_pend[p] || rr[p]);
        g = -1;
        if (el[0] && el[1]) g = (m_last == 0) ? 1 : 0;
        else if (el[0])     g = 0;
        else if (el[1])     g = 1;
        check({tag, " inst_req_ready"}, 32'(inst_req_ready), 32'(g == 0));
        check({tag, " data_req_ready"}, 32'(data_req_ready), 32'(g == 1));
        check({tag, " ram_enabled"}, 32'(ram_enabled), 32'(g >= 0));
        check({tag, " ram_strobe"}, 32'(ram_write_strobe),
              (g >= 0) ? 32'(s[g]) : 32'h0);
        check({tag, " ram_addr"}, ram_address, (g >= 0) ? a[g] : 32'h0);
        check({tag, " ram_wdata"}, ram_write_data, (g >= 0) ? w[g] : 32'h0);
        check({tag, " inst_resp_valid"}, 32'(inst_resp_valid), 32'(m_pend[0]));
        check({tag, " data_resp_valid"}, 32'(data_resp_valid), 32'(m_pend[1]));
        if (m_pend[0]) check({tag, " inst_resp_data"}, inst_resp_data, m_data[0]);
        if (m_pend[1]) check({tag, " data_resp_data"}, data_resp_data, m_data[1]);
        for (int p = 0; p < 2; p++)
            if (m_pend[p] && rr[p]) m_pend[p] = 0;
        if (g >= 0) begin
            m_pend[g] = 1;
            m_data[g] = (s[g] == 0) ? mem[a[g][9:2]] : 32'h0;
            m_last = g;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req_valid = 0; data_req_valid = 0;
        inst_req_write_strobe = 0; data_req_write_strobe = 0;
        inst_resp_ready = 1; data_resp_ready = 1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        model_reset();

        // Outputs held low under reset even with requests present
        inst_req_valid = 1; data_req_valid = 1;
        #2;
        check("rst inst_req_ready", 32'(inst_req_ready), 0);
        check("rst data_req_ready", 32'(data_req_ready), 0);
        check("rst ram_enabled", 32'(ram_enabled), 0);
        check("rst inst_resp_valid", 32'(inst_resp_valid), 0);
        check("rst data_resp_valid", 32'(data_resp_valid), 0);
        @(posedge clock); #1;
        reset = 0;

        // Tie after reset: data first, then alternate
        inst_req_address = 32'h40; data_req_address = 32'h80;
        for (int i = 0; i < 4; i++) step("tie");
        idle_inputs();
        step("drain1");

        // Back-to-back inst reads of 0x100
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        inst_req_valid = 1; inst_req_address = 32'h100;
        step("ird0");
        check("ird resp_valid", 32'(inst_resp_valid), 1);
        check("ird resp_data", inst_resp_data, 32'hDEADBEEF);
        step("ird1");
        step("ird2");

        // Data response stalled three cycles; inst keeps flowing
        data_req_valid = 1; data_req_address = 32'h24;
        data_resp_ready = 0;
        for (int i = 0; i < 4; i++) step("dstall");
        data_req_valid = 0;
        data_resp_ready = 1;
        step("dstall_rel");
        idle_inputs();
        step("drain2");

        // Data full-word write
        data_req_valid = 1; data_req_write_strobe = 4'hF;
        data_req_address = 32'h30; data_req_write_data = 32'h12345678;
        step("dwr");
        check("dwr resp_valid", 32'(data_resp_valid), 1);
        check("dwr resp_data", data_resp_data, 0);
        idle_inputs();
        step("dwr_after");
        check("dwr mem", mem[32'h30 >> 2], 32'h12345678);

        // Reset while an inst read is in flight
        inst_req_valid = 1; inst_req_address = 32'h100;
        step("rflight");
        reset = 1;
        #1;
        check("rfl inst_resp_valid", 32'(inst_resp_valid), 0);
        check("rfl inst_req_ready", 32'(inst_req_ready), 0);
        check("rfl ram_enabled", 32'(ram_enabled), 0);
        @(posedge clock); #1;
        reset = 0;
        model_reset();
        data_req_valid = 1; data_req_address = 32'h8;
        step("rfl_tie");
        idle_inputs();
        step("rfl_drain");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            inst_req_valid = ($urandom_range(0, 9) < 7);
            data_req_valid = ($urandom_range(0, 9) < 7);
            inst_resp_ready = ($urandom_range(0, 9) < 7);
            data_resp_ready = ($urandom_range(0, 9) < 7);
            inst_req_write_strobe = $urandom_range(0, 1) ? 4'(0) : 4'($urandom);
            data_req_write_strobe = $urandom_range(0, 1) ? 4'(0) : 4'($urandom);
            inst_req_address = $urandom;
            data_req_address = $urandom;
            inst_req_write_data = $urandom;
            data_req_write_data = $urandom;
            step("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
